cache_refill: RTL

Miss-handling engine placed between the cache set array and the 32-bit memory bus. It accepts a miss, writes the selected victim line back to memory when it is dirty, fetches the new line one word at a time, and writes the filled line into the set's replacement way. It drives the set write port (`we/wp/wd/ctag_w/data_w`) and consumes the set's victim outputs (`r_dirty/r_ctag/r_data`).

---
 rtl/cache_refill_pkg.sv | 24 ++
 rtl/refill_buf.sv | 37 +++
 rtl/cache_refill.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_pkg.sv
// Shared types and helpers for the cache refill engine.
// The optional victim writeback path is enabled by defining CACHE_WRITEBACK_EN.
package cache_refill_pkg;

  localparam int LINE_WORDS = 4;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD_REQ,
    RD_WAIT,
    FILL
  } refill_state_t;

  // Builds the bus word address {tag, idx, word, 2'b00} from zero-extended fields.
  function automatic logic [31:0] compose_addr(input logic [31:0] tag,
                                               input logic [31:0] idx,
                                               input logic [31:0] word,
                                               input int          idx_w,
                                               input int          word_w);
    return ((((tag << idx_w) | idx) << word_w) | word) << 2;
  endfunction

endpackage

// File: rtl/refill_buf.sv
// Word-addressed line buffer for the refill engine: whole-line load,
// single-word write, a word read port for writeback, and the full line.
module refill_buf #(
  parameter int LINE_WORDS = 4,
  parameter int WSEL_W     = $clog2(LINE_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [32*LINE_WORDS-1:0] load_line_i,
  input  logic                    wr_en_i,
  input  logic [WSEL_W-1:0]       wr_idx_i,
  input  logic [31:0]             wr_data_i,
  input  logic [WSEL_W-1:0]       rd_idx_i,
  output logic [31:0]             rd_data_o,
  output logic [32*LINE_WORDS-1:0] line_o
);

  logic [31:0] words_q [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++) words_q[i] <= '0;
    end else if (load_i) begin
      for (int i = 0; i < LINE_WORDS; i++) words_q[i] <= load_line_i[32*i +: 32];
    end else if (wr_en_i) begin
      words_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = words_q[rd_idx_i];

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_line
    assign line_o[32*g +: 32] = words_q[g];
  end

endmodule

// File: rtl/cache_refill.sv
// Cache miss engine: optional dirty-victim writeback, word-by-word line fetch,
// then one set write. Writeback exists only when CACHE_WRITEBACK_EN is defined.
module cache_refill
  import cache_refill_pkg::*;
#(
  parameter int TAG_W      = 22,
  parameter int IDX_W      = 6,
  parameter int LINE_WORDS = cache_refill_pkg::LINE_WORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IDX_W-1:0]        req_idx,
  input  logic [TAG_W-1:0]        req_ctag,
  input  logic                    vic_dirty,
  input  logic [TAG_W-1:0]        vic_ctag,
  input  logic [32*LINE_WORDS-1:0] vic_data,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        set_idx,
  output logic                    set_we,
  output logic                    set_wp,
  output logic                    set_wd,
  output logic [TAG_W-1:0]        set_ctag_w,
  output logic [32*LINE_WORDS-1:0] set_data_w,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [31:0]             mem_rdata
);

  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam logic [WSEL_W-1:0] LAST = WSEL_W'(LINE_WORDS - 1);

  refill_state_t     state_q;
  logic [WSEL_W-1:0] cnt_q;
  logic [WSEL_W-1:0] cnt_inc;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  ctag_q;
  logic              busy_q, done_q, set_we_q, mem_req_q, mem_we_q;
  logic [31:0]       mem_addr_q, mem_wdata_q;

  logic                     buf_wr, buf_load;
  logic [32*LINE_WORDS-1:0] buf_load_line;
  logic [WSEL_W-1:0]        buf_rd_idx;
  logic [31:0]              buf_rd;

  assign cnt_inc = cnt_q + WSEL_W'(1);
  assign buf_wr  = (state_q == RD_WAIT) && mem_rvalid;

`ifdef CACHE_WRITEBACK_EN
  logic [TAG_W-1:0] vtag_q;
  // The victim line is parked in the fill buffer; it is fully drained before the first read lands.
  assign buf_load      = (state_q == IDLE) && start && vic_dirty;
  assign buf_load_line = vic_data;
  assign buf_rd_idx    = cnt_inc;
`else
  logic unused_vic;
  assign unused_vic    = ^{vic_dirty, vic_ctag, vic_data, buf_rd};
  assign buf_load      = 1'b0;
  assign buf_load_line = '0;
  assign buf_rd_idx    = '0;
`endif

  refill_buf #(
    .LINE_WORDS (LINE_WORDS),
    .WSEL_W     (WSEL_W)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (buf_load),
    .load_line_i (buf_load_line),
    .wr_en_i     (buf_wr),
    .wr_idx_i    (cnt_q),
    .wr_data_i   (mem_rdata),
    .rd_idx_i    (buf_rd_idx),
    .rd_data_o   (buf_rd),
    .line_o      (set_data_w)
  );

  // Bus outputs are set up one cycle ahead, on the transition into the state that presents them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      ctag_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      set_we_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef CACHE_WRITEBACK_EN
      vtag_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q     <= req_idx;
            ctag_q    <= req_ctag;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            mem_req_q <= 1'b1;
`ifdef CACHE_WRITEBACK_EN
            vtag_q    <= vic_ctag;
            if (vic_dirty) begin
              state_q     <= WB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= compose_addr(32'(vic_ctag), 32'(req_idx), 32'd0, IDX_W, WSEL_W);
              mem_wdata_q <= vic_data[31:0];
            end else begin
              state_q     <= RD_REQ;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= compose_addr(32'(req_ctag), 32'(req_idx), 32'd0, IDX_W, WSEL_W);
            end
`else
            state_q    <= RD_REQ;
            mem_we_q   <= 1'b0;
            mem_addr_q <= compose_addr(32'(req_ctag), 32'(req_idx), 32'd0, IDX_W, WSEL_W);
`endif
          end
        end
`ifdef CACHE_WRITEBACK_EN
        WB: begin
          if (mem_ready) begin
            if (cnt_q == LAST) begin
              cnt_q       <= '0;
              state_q     <= RD_REQ;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
              mem_addr_q  <= compose_addr(32'(ctag_q), 32'(idx_q), 32'd0, IDX_W, WSEL_W);
            end else begin
              cnt_q       <= cnt_inc;
              mem_wdata_q <= buf_rd;
              mem_addr_q  <= compose_addr(32'(vtag_q), 32'(idx_q), 32'(cnt_inc), IDX_W, WSEL_W);
            end
          end
        end
`endif
        RD_REQ: begin
          if (mem_ready) begin
            state_q   <= RD_WAIT;
            mem_req_q <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            if (cnt_q == LAST) begin
              state_q  <= FILL;
              set_we_q <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              cnt_q      <= cnt_inc;
              state_q    <= RD_REQ;
              mem_req_q  <= 1'b1;
              mem_addr_q <= compose_addr(32'(ctag_q), 32'(idx_q), 32'(cnt_inc), IDX_W, WSEL_W);
            end
          end
        end
        FILL: begin
          state_q  <= IDLE;
          set_we_q <= 1'b0;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign set_we     = set_we_q;
  assign set_wp     = 1'b1;
  assign set_wd     = 1'b0;
  assign set_idx    = idx_q;
  assign set_ctag_w = ctag_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
